axi4_lite_regfile: RTL and testbench
====================================

# axi4_lite_regfile

Parametrised AXI4-Lite slave register file: the next-generation AXI4-Lite slave for the AMBA design set, generalising the fixed 3-bit-address / 32-bit slave to configurable data width, register count and byte-lane strobes. Accepts write address and write data in either order, gives a fixed-latency read path and an error response for unmapped addresses. Sits behind an AXI4-Lite interconnect port. All registers are exported flat to user logic.

## Interface
- ADDR_WIDTH, 5, byte address width.
- DATA_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 6, implemented registers; must satisfy NUM_REGS ≤ 2^(ADDR_WIDTH−log2(DATA_WIDTH/8)).
- STRB_WIDTH (derived, DATA_WIDTH/8), byte-lane count.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  synchronous, active-low reset.
- awaddr  in  ADDR_WIDTH  write byte address.
- awprot  in  3  ignored.
- awvalid / awready  in / out  1  write-address handshake.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte-lane enables.
- wvalid / wready  in / out  1  write-data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write-response handshake.
- araddr  in  ADDR_WIDTH  read byte address.
- arprot  in  3  ignored.
- arvalid / arready  in / out  1  read-address handshake.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid / rready  out / in  1  read-data handshake.
- regs_out  out  NUM_REGS*DATA_WIDTH  register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Word index = addr[ADDR_WIDTH−1 : log2(STRB_WIDTH)]. Low address bits are ignored. Index ≥ NUM_REGS is unmapped.
- Write path: the AW and W slots are independent one-entry holding registers.
  - Each slot captures on its handshake edge; its ready is then 0 until the slot empties.
  - When both slots are full and bvalid=0, the write commits on the next edge. Byte lane k of the target register updates iff wstrb[k]=1.
  - bvalid rises on that same edge, both slots clear, and bresp is set.
  - bvalid holds, with bresp stable, until bready=1. awready and wready stay 0 while bvalid=1.
  - Both return to 1 on the edge after the B handshake.
- wstrb=0: no register change; bresp=OKAY.
- Read path: arready=1 when idle. On the AR handshake edge:
  - arready drops to 0.
  - rdata, rresp and rvalid load.
  - rvalid holds, with rdata and rresp stable, until rready=1.
  - arready returns to 1 on the edge after the R handshake.
- rdata samples register contents before any write committing on the same edge. A simultaneous read returns the old value.
- Read and write paths are fully concurrent.
- Unmapped access: the write is discarded and rdata=0. The response depends on the configuration (see below).
- Reset (aresetn=0 at an edge):
  - All registers clear to 0; slots empty.
  - bvalid, rvalid, bresp, rresp, rdata and all readies go to 0. Any in-flight transaction is dropped.
  - awready, wready and arready go to 1 at the first edge with aresetn=1.

## Timing
- Write latency: bvalid is high one edge after the later of the AW/W handshakes. regs_out updates on the same edge.
- Minimum write issue interval: 3 cycles, with bready held at 1.
- Read latency: rvalid is high one edge after the AR handshake.
- Minimum read issue interval: 2 cycles, with rready held at 1.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- AXI_LITE_SLVERR_EN defined:
  - Unmapped writes return bresp=2'b10 (SLVERR).
  - Unmapped reads return rresp=2'b10 with rdata=0.
- AXI_LITE_SLVERR_EN undefined:
  - Unmapped accesses return OKAY (2'b00).
  - Unmapped writes are still discarded; unmapped reads still return 0.

## Test plan
- AW before W: awaddr=0x04 then wdata=0x64 with wstrb=0xF one cycle later -> bresp=00 one edge after the W handshake; read 0x04 returns 0x00000064; regs_out[63:32]=0x64.
- W two cycles before AW: addr 0x08, data 0xC8, bready held 0 for 3 cycles -> bvalid stays 1 and awready/wready stay 0 until bready; read 0x08 returns 0xC8.
- Strobes: write 0x11223344 to 0x0C with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5 -> read 0x0C returns 0x11BB33DD.
- Unmapped: write 0xFF to 0x18 (index 6), then read 0x18 -> with macro bresp=rresp=2'b10; without, both 2'b00; rdata=0 and regs_out unchanged in both builds.
- Same-edge read and write: 0x00 holds 0x5; AW, W (0x9) and AR to 0x00 all in one cycle -> rdata=0x5; the following read returns 0x9.
- Reset mid-write: AW handshake to 0x04, then aresetn=0 for one cycle before W -> all regs=0, bvalid=0; readies=1 one edge after release; the subsequent W alone produces no bvalid.

Source files
------------

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent AW/W holding slots, byte strobes and flat register export.
// Define AXI_LITE_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
module axi4_lite_regfile #(
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 6,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  commit;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  // Write path: slots fill independently; a full pair commits once the previous response has drained.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    commit    = aw_full_q && w_full_q && !bvalid_q;

    if (awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr[ADDR_WIDTH-1:ADDR_LSB];
    end
    if (wvalid && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata;
      w_strb_d = wstrb;
    end
    if (bvalid_q && bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = is_mapped(aw_idx_q) ? RESP_OKAY : RESP_UNMAPPED;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (32'(aw_idx_q) == 32'(i)) begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (w_strb_q[k]) regs_d[i][k*8 +: 8] = w_data_q[k*8 +: 8];
          end
        end
      end
    end

    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  // Read path: sampled from the pre-commit register state, so a same-edge write is not visible.
  always_comb begin
    rd_idx  = araddr[ADDR_WIDTH-1:ADDR_LSB];
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == 32'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = is_mapped(rd_idx) ? rd_word : '0;
      rresp_d  = is_mapped(rd_idx) ? RESP_OKAY : RESP_UNMAPPED;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Scoreboard bench for axi4_lite_regfile: stimulus queues expected B/R responses, a monitor pops and compares.
module tb_axi4_lite_regfile;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 6;
  localparam int SW = DW / 8;
`ifdef AXI_LITE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [AW-1:0]     awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  regs_out;

  axi4_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [1:0]  mon_eb;
  logic [33:0] mon_er;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each accepted B/R beat is compared against the oldest queued expectation.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && bvalid && bready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        mon_eb = exp_b.pop_front();
        chk("bresp", bresp, mon_eb);
      end
    end
    if (aresetn === 1'b1 && rvalid && rready) begin
      if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        mon_er = exp_r.pop_front();
        chk("rresp", rresp, mon_er[33:32]);
        chk("rdata", rdata, mon_er[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_hs(input logic [AW-1:0] a);
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic r;
      r = awready;
      tick();
      if (r) begin
        awvalid = 1'b0;
        return;
      end
    end
    awvalid = 1'b0;
    chk("aw_timeout", 1, 0);
  endtask

  task automatic w_hs(input logic [DW-1:0] d, input logic [SW-1:0] s);
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic r;
      r = wready;
      tick();
      if (r) begin
        wvalid = 1'b0;
        return;
      end
    end
    wvalid = 1'b0;
    chk("w_timeout", 1, 0);
  endtask

  task automatic ar_hs(input logic [AW-1:0] a);
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic r;
      r = arready;
      tick();
      if (r) begin
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    chk("ar_timeout", 1, 0);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                       input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      aw_hs(a);
      w_hs(d, s);
    join
    repeat (3) tick();
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [1:0] resp, input logic [DW-1:0] d);
    exp_r.push_back({resp, d});
    ar_hs(a);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;

    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_regs", regs_out, 0);
    aresetn = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // AW first, W one cycle later
    exp_b.push_back(2'b00);
    aw_hs(5'h04);
    w_hs(32'h64, 4'hF);
    chk("aww_bvalid_early", bvalid, 0);
    tick();
    chk("aww_bvalid", bvalid, 1);
    chk("aww_regs1", regs_out[63:32], 32'h64);
    repeat (2) tick();
    read(5'h04, 2'b00, 32'h64);

    // W two cycles ahead of AW, B held off
    bready = 1'b0;
    exp_b.push_back(2'b00);
    w_hs(32'hC8, 4'hF);
    tick();
    tick();
    aw_hs(5'h08);
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("hold_bvalid", bvalid, 1);
      chk("hold_awready", awready, 0);
      chk("hold_wready", wready, 0);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("post_b_bvalid", bvalid, 0);
    chk("post_b_awready", awready, 1);
    chk("post_b_wready", wready, 1);
    read(5'h08, 2'b00, 32'hC8);

    // Byte strobes, and low address bits ignored on read
    write(5'h0C, 32'h11223344, 4'hF, 2'b00);
    write(5'h0C, 32'hAABBCCDD, 4'h5, 2'b00);
    read(5'h0C, 2'b00, 32'h11BB33DD);
    read(5'h0E, 2'b00, 32'h11BB33DD);

    // Unmapped indices 6 and 7
    write(5'h18, 32'hFF, 4'hF, ERR);
    chk("unmapped_regs", regs_out, {32'h0, 32'h0, 32'h11BB33DD, 32'hC8, 32'h64, 32'h0});
    read(5'h18, ERR, 32'h0);
    read(5'h1C, ERR, 32'h0);

    // Zero strobe leaves the register untouched
    write(5'h04, 32'hDEADBEEF, 4'h0, 2'b00);
    chk("strb0_regs1", regs_out[63:32], 32'h64);

    // Read and write to the same register in one cycle
    write(5'h00, 32'h5, 4'hF, 2'b00);
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h5});
    awaddr = 5'h00; awvalid = 1'b1;
    wdata = 32'h9; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 5'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (3) tick();
    read(5'h00, 2'b00, 32'h9);

    // Reset between AW and W drops the pending write
    aw_hs(5'h04);
    aresetn = 1'b0;
    tick();
    chk("mid_rst_regs", regs_out, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_awready", awready, 0);
    aresetn = 1'b1;
    tick();
    chk("mid_rel_awready", awready, 1);
    chk("mid_rel_wready", wready, 1);
    chk("mid_rel_arready", arready, 1);
    w_hs(32'h77, 4'hF);
    for (int n = 0; n < 4; n++) begin
      chk("lone_w_bvalid", bvalid, 0);
      tick();
    end
    chk("lone_w_regs", regs_out, 0);

    chk("sb_drain", exp_b.size() + exp_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
